// File: rtl/score_pkg.sv
// Shared constants and types for the diamond score keeper and its helpers.
package score_pkg;

    localparam int NUM_DIAMONDS = 16;
    localparam int IDX_W        = 4;
    localparam int SCORE_W      = 5;
    localparam int SYNC_STAGES  = 2;

    typedef enum logic [1:0] {
        HS_IDLE = 2'd0,
        HS_EVAL = 2'd1,
        HS_ACK  = 2'd2
    } hs_state_t;

    typedef logic [SCORE_W-1:0] score_t;

    localparam score_t SCORE_MAX = score_t'(NUM_DIAMONDS);

endpackage

// File: rtl/score_keeper_req_sync.sv
// Single-bit multi-flop synchroniser; clears to 0 on asynchronous reset.
module req_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_chain <= '0;
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/score_keeper.sv
// Counts distinct collected diamonds from a 4-phase req/ack handshake and
// flags the win once every diamond has been taken.
module score_keeper
    import score_pkg::*;
(
    input  logic                    segclk,
    input  logic                    reset,
    input  logic                    new_game,
    input  logic                    hit_req,
    input  logic [IDX_W-1:0]        hit_idx,
    output logic                    hit_ack,
    output score_t                  score,
    output logic [NUM_DIAMONDS-1:0] collected,
    output logic                    game_won,
    output logic                    dup_hit,
    output hs_state_t               o_dbg_state
);

    // Handshake: the requester raises hit_req with hit_idx stable and holds it
    // until hit_ack is seen high; it then drops hit_req and hit_ack follows it
    // low. A request is taken only from HS_IDLE, so one handshake = one count.

    localparam logic [IDX_W:0] IDX_LIMIT = (IDX_W+1)'(NUM_DIAMONDS);

    hs_state_t               r_state;
    logic [IDX_W-1:0]        r_idx_q;
    logic [NUM_DIAMONDS-1:0] r_collected;
    score_t                  r_score;
    logic                    r_game_won;
    logic                    r_hit_ack;
    logic                    r_dup_hit;

    hs_state_t w_state_nxt;
    logic      w_req_s;
    logic      w_latch;
    logic      w_accept;
    logic      w_reject;
    logic      w_idx_valid;
    logic      w_taken;
    score_t    w_score_inc;

    req_sync #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .i_clk (segclk),
        .i_rst (reset),
        .i_d   (hit_req),
        .o_q   (w_req_s)
    );

    assign w_idx_valid = ({1'b0, r_idx_q} < IDX_LIMIT);
    assign w_taken     = w_idx_valid && r_collected[r_idx_q];
    // Saturation guards against wrap; the bitmap already prevents reaching it.
    assign w_score_inc = (r_score == SCORE_MAX) ? r_score : r_score + score_t'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            HS_IDLE: begin
                if (w_req_s) begin
                    if (r_game_won) begin
                        w_state_nxt = HS_ACK;
                    end else begin
                        w_latch     = 1'b1;
                        w_state_nxt = HS_EVAL;
                    end
                end
            end
            HS_EVAL: begin
                w_state_nxt = HS_ACK;
                // new_game discards the pending hit without flagging it
                if (!new_game) begin
                    if (!w_idx_valid || w_taken) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                    end
                end
            end
            HS_ACK: begin
                if (!w_req_s) begin
                    w_state_nxt = HS_IDLE;
                end
            end
            default: begin
                w_state_nxt = HS_IDLE;
            end
        endcase
    end

    always_ff @(posedge segclk or posedge reset) begin
        if (reset) begin
            r_state   <= HS_IDLE;
            r_idx_q   <= '0;
            r_hit_ack <= 1'b0;
            r_dup_hit <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_hit_ack <= (w_state_nxt == HS_ACK);
            r_dup_hit <= w_reject;
            if (w_latch) begin
                r_idx_q <= hit_idx;
            end
        end
    end

    always_ff @(posedge segclk or posedge reset) begin
        if (reset) begin
            r_collected <= '0;
            r_score     <= '0;
            r_game_won  <= 1'b0;
        end else if (new_game) begin
            r_collected <= '0;
            r_score     <= '0;
            r_game_won  <= 1'b0;
        end else if (w_accept) begin
            r_collected[r_idx_q] <= 1'b1;
            r_score              <= w_score_inc;
            r_game_won           <= r_game_won | (w_score_inc == SCORE_MAX);
        end
    end

    assign hit_ack     = r_hit_ack;
    assign score       = r_score;
    assign collected   = r_collected;
    assign game_won    = r_game_won;
    assign dup_hit     = r_dup_hit;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: a reference model pushes the expected
// outcome of each request, popped and compared when hit_ack rises.
module tb_score_keeper;
    import score_pkg::*;

    logic                    segclk;
    logic                    reset;
    logic                    new_game;
    logic                    hit_req;
    logic [IDX_W-1:0]        hit_idx;
    logic                    hit_ack;
    score_t                  score;
    logic [NUM_DIAMONDS-1:0] collected;
    logic                    game_won;
    logic                    dup_hit;
    hs_state_t               o_dbg_state;

    score_keeper dut (
        .segclk      (segclk),
        .reset       (reset),
        .new_game    (new_game),
        .hit_req     (hit_req),
        .hit_idx     (hit_idx),
        .hit_ack     (hit_ack),
        .score       (score),
        .collected   (collected),
        .game_won    (game_won),
        .dup_hit     (dup_hit),
        .o_dbg_state (o_dbg_state)
    );

    // clock / reset
    initial segclk = 1'b0;
    always #5 segclk = ~segclk;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // model state; expected entry = {dup, won, score, collected}
    logic [NUM_DIAMONDS-1:0] m_coll;
    int                      m_score;
    logic                    m_won;
    int                      exp_lat;
    logic [22:0]             exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_coll  = '0;
        m_score = 0;
        m_won   = 1'b0;
    endtask

    // predicts one request; ng = new_game lands on the evaluation cycle
    task automatic model_push(input int idx, input bit ng);
        logic dup;
        dup = 1'b0;
        if (m_won && !ng) begin
            exp_lat = 3;
        end else begin
            exp_lat = 4;
            if (ng) begin
                model_clear();
            end else if (m_coll[idx]) begin
                dup = 1'b1;
            end else begin
                m_coll[idx] = 1'b1;
                m_score++;
                m_won = (m_score == NUM_DIAMONDS);
            end
        end
        exp_q.push_back({dup, m_won, 5'(m_score), m_coll});
    endtask

    // driver tasks
    task automatic start_hit(input int idx, input bit ng);
        model_push(idx, ng);
        hit_idx = IDX_W'(idx);
        hit_req = 1'b1;
    endtask

    task automatic wait_ack(input bit ng);
        int n;
        logic [22:0] e;
        n = 0;
        while (n < 20) begin
            @(posedge segclk);
            #1;
            n++;
            new_game = (ng && n == 3);
            if (hit_ack) break;
        end
        new_game = 1'b0;
        check("ack_latency", 32'(n), 32'(exp_lat));
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'(1), 32'(0));
        end else begin
            e = exp_q.pop_front();
            check("dup_hit",   32'(dup_hit),   32'(e[22]));
            check("game_won",  32'(game_won),  32'(e[21]));
            check("score",     32'(score),     32'(e[20:16]));
            check("collected", 32'(collected), 32'(e[15:0]));
        end
    endtask

    task automatic finish_hit();
        int m;
        hit_req = 1'b0;
        m = 0;
        while (m < 20) begin
            @(posedge segclk);
            #1;
            m++;
            if (m == 1) check("dup_pulse", 32'(dup_hit), 32'(0));
            if (!hit_ack) break;
        end
        check("ack_fall", 32'(m), 32'(3));
        @(posedge segclk);
        #1;
    endtask

    task automatic hit(input int idx, input bit ng);
        start_hit(idx, ng);
        wait_ack(ng);
        finish_hit();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_score"}, 32'(score),     32'(0));
        check({tag, "_coll"},  32'(collected), 32'(0));
        check({tag, "_ack"},   32'(hit_ack),   32'(0));
        check({tag, "_won"},   32'(game_won),  32'(0));
    endtask

    initial begin
        int guard;
        reset    = 1'b1;
        new_game = 1'b0;
        hit_req  = 1'b0;
        hit_idx  = '0;
        model_clear();
        #1;
        check_cleared("rst_init");
        check("rst_dup", 32'(dup_hit), 32'(0));
        repeat (2) @(posedge segclk);
        #1;
        reset = 1'b0;
        @(posedge segclk);
        #1;

        // single hit, then duplicate
        hit(5, 0);
        hit(5, 0);

        // random hits until score reaches 7, then asynchronous reset
        guard = 0;
        while (m_score < 7 && guard < 60) begin
            hit($urandom_range(0, NUM_DIAMONDS - 1), 0);
            guard++;
        end
        check("reach7", 32'(score), 32'(7));
        reset = 1'b1;
        #1;
        check_cleared("rst_mid");
        check("rst_state", 32'(o_dbg_state), 32'(HS_IDLE));
        model_clear();
        @(posedge segclk);
        #1;
        reset = 1'b0;
        @(posedge segclk);
        #1;

        // new_game colliding with evaluation of idx 9 at score 4
        for (int i = 0; i < 4; i++) hit(i, 0);
        check("pre_ng", 32'(score), 32'(4));
        hit(9, 1);

        // win sequence and a post-win request
        for (int i = 0; i < NUM_DIAMONDS; i++) hit(i, 0);
        hit(3, 0);

        // plain new_game clears progress
        new_game = 1'b1;
        @(posedge segclk);
        #1;
        new_game = 1'b0;
        model_clear();
        check_cleared("new_game");

        // reset while acknowledging idx 2, request still held afterwards
        start_hit(2, 0);
        wait_ack(0);
        reset = 1'b1;
        #1;
        check_cleared("rst_ack");
        model_clear();
        @(posedge segclk);
        #1;
        reset = 1'b0;
        model_push(2, 0);
        wait_ack(0);
        finish_hit();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Upstream neighbour of the two-digit score display; produces the 5-bit `score` the display decodes.
- Receives "diamond collected" requests from game logic over a 4-phase req/ack handshake; `hit_req` is synchronised into segclk.
- Tracks which diamonds are already taken. Each distinct diamond counts exactly once.
- Flags the win when all diamonds are collected.

Parameters:
- NUM_DIAMONDS, 16, number of collectable diamonds; also the maximum score.
- IDX_W, 4, width of the diamond index.
- SCORE_W, 5, score width; must hold NUM_DIAMONDS.
- SYNC_STAGES, 2, flop stages on hit_req.

Ports:
- segclk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- new_game  input  1  synchronous (segclk domain) level; clears game progress.
- hit_req  input  1  asynchronous request from game logic; held high until hit_ack seen.
- hit_idx  input  IDX_W  diamond index; stable whenever hit_req is high.
- hit_ack  output  1  registered acknowledge.
- score  output  SCORE_W  diamonds collected, 0..NUM_DIAMONDS; feeds the display.
- collected  output  NUM_DIAMONDS  bitmap of taken diamonds.
- game_won  output  1  high while score == NUM_DIAMONDS.
- dup_hit  output  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset: score=0, collected=0, game_won=0, hit_ack=0, dup_hit=0, sync chain=0, FSM=HS_IDLE.
- hit_req passes through SYNC_STAGES flops, giving req_s.
- FSM states: HS_IDLE, HS_EVAL, HS_ACK.
- HS_IDLE:
  - req_s=1 and game_won=0 -> latch hit_idx into idx_q, go to HS_EVAL.
  - req_s=1 and game_won=1 -> go to HS_ACK. No evaluation; dup_hit stays low.
  - Otherwise stay.
- HS_EVAL (one cycle), always goes to HS_ACK:
  - idx_q >= NUM_DIAMONDS, or collected[idx_q]=1 -> dup_hit=1 for this edge's output; no state change.
  - Otherwise collected[idx_q]<=1 and score<=score+1.
- HS_ACK: hit_ack=1. When req_s=0 -> hit_ack<=0, go to HS_IDLE.
- Latency:
  - Let edge 0 be the first segclk edge sampling hit_req=1.
  - score, collected, dup_hit and hit_ack all update on edge SYNC_STAGES+1 (edge 3 at default).
  - hit_ack falls on edge SYNC_STAGES after hit_req is first sampled low.
- Score arithmetic:
  - Unsigned and saturating at NUM_DIAMONDS; saturation is defensive and unreachable by construction.
  - score always equals popcount(collected).
- game_won is registered. It sets on the same edge score becomes NUM_DIAMONDS and clears only on new_game or reset.
- new_game=1:
  - Next edge: score=0, collected=0, game_won=0.
  - Handshake FSM and hit_ack are unaffected, so an in-flight ack completes normally.
  - If new_game coincides with HS_EVAL, new_game wins. The hit is discarded, no dup_hit pulse, and the FSM still goes to HS_ACK.
- Reset mid-handshake:
  - Ack drops and progress is lost.
  - If hit_req is still high after reset, the request is treated as new and counts against the cleared bitmap.
- A new request is never evaluated before req_s has returned low. One count per handshake.

Decomposition:
- Package score_pkg holds:
  - constants NUM_DIAMONDS, IDX_W, SCORE_W, SYNC_STAGES;
  - typedef enum logic [1:0] hs_state_t {HS_IDLE, HS_EVAL, HS_ACK};
  - typedef logic [SCORE_W-1:0] score_t.
- One sub-module, req_sync: a SYNC_STAGES-deep single-bit synchroniser with async reset to 0.
- The FSM, bitmap and score stay in score_keeper.

Test Plan:
- Reset mid-run:
  - Stimulus: reset pulse with score=7, then release.
  - Response: score=0, collected=16'h0000, hit_ack=0, game_won=0 immediately (asynchronous); FSM idle.
- Single hit:
  - Stimulus: hit_idx=5, hit_req held high.
  - Response: on edge 3, score=1, collected=16'h0020, hit_ack=1.
  - Then drop hit_req: hit_ack=0 two edges after it is first sampled low.
- Duplicate:
  - Stimulus: hit idx 5 twice.
  - Response: second handshake gives a dup_hit one-cycle pulse, score stays 1, hit_ack still completes.
- Win:
  - Stimulus: hits idx 0..15 in order.
  - Response: score=16, collected=16'hFFFF, game_won=1 on the edge of the 16th update.
  - A 17th request (idx 3) is acked with no dup_hit and score stays 16.
- new_game collision:
  - Stimulus: new_game during HS_EVAL of idx 9 with score=4.
  - Response: score=0, collected=0, no dup_hit, hit_ack still rises.
- Reset during HS_ACK:
  - Stimulus: reset while hit_req is held with idx 2.
  - Response: hit_ack=0. After release, the request is re-evaluated: score=1, collected=16'h0004.
